// File: rtl/mem_access_pkg.sv
// Shared FSM encoding and default widths for the memory access sequencer.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int STATS_W    = 16;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus memory-side bus of the access sequencer.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Environment side: datapath control plus the memory array.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access sequencer with MDR and programmable read wait.
// Optional access statistics enabled by defining MEM_ACCESS_STATS_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_ctrl_if.slave    bus
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [STATS_W-1:0]  rd_count,
    output logic [STATS_W-1:0]  wr_count
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_WAIT - 1);

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mdr;
    logic                mem_read_q, mem_write_q, rsp_valid_q;
    logic                accept, rd_done;

    assign accept  = (state == IDLE) && bus.req_valid;
    assign rd_done = (state == RD) && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = bus.req_we ? WR : RD;
            RD:      if (wait_cnt == '0) state_next = RESP;
            WR:      state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are flopped from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mdr         <= '0;
            wait_cnt    <= '0;
        end else begin
            mem_read_q  <= (state_next == RD);
            mem_write_q <= (state_next == WR);
            rsp_valid_q <= (state_next == RESP);
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (!bus.req_we) wait_cnt <= WAIT_INIT;
            end
            if (state == RD) begin
                if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                else                mdr      <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = mdr;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef MEM_ACCESS_STATS_EN
    sat_counter #(.WIDTH(STATS_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_done),
        .count (rd_count)
    );

    sat_counter #(.WIDTH(STATS_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == WR),
        .count (wr_count)
    );
`else
    logic unused_rd_done;
    assign unused_rd_done = rd_done;
`endif

endmodule
